// File: rtl/udma_spis_mc_reg.sv
// uDMA SPI-slave register file: N_CH RX/TX channel register sets, SPI setup,
// frame-length fields, SEOT event counter and a masked sticky IRQ block.
module udma_spis_mc_reg #(
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16,
  parameter int unsigned N_CH           = 2,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned CNT_SAT        = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,

  input  logic [31:0]                      cfg_data_i,
  input  logic [5:0]                       cfg_addr_i,
  input  logic                             cfg_valid_i,
  input  logic                             cfg_rwn_i,
  output logic [31:0]                      cfg_data_o,
  output logic                             cfg_ready_o,

  output logic [N_CH*L2_AWIDTH_NOAL-1:0]   cfg_rx_startaddr_o,
  output logic [N_CH*TRANS_SIZE-1:0]       cfg_rx_size_o,
  output logic [N_CH-1:0]                  cfg_rx_continuous_o,
  output logic [N_CH-1:0]                  cfg_rx_en_o,
  output logic [N_CH-1:0]                  cfg_rx_clr_o,
  input  logic [N_CH-1:0]                  cfg_rx_en_i,
  input  logic [N_CH-1:0]                  cfg_rx_pending_i,
  input  logic [N_CH*L2_AWIDTH_NOAL-1:0]   cfg_rx_curr_addr_i,
  input  logic [N_CH*TRANS_SIZE-1:0]       cfg_rx_bytes_left_i,

  output logic [N_CH*L2_AWIDTH_NOAL-1:0]   cfg_tx_startaddr_o,
  output logic [N_CH*TRANS_SIZE-1:0]       cfg_tx_size_o,
  output logic [N_CH-1:0]                  cfg_tx_continuous_o,
  output logic [N_CH-1:0]                  cfg_tx_en_o,
  output logic [N_CH-1:0]                  cfg_tx_clr_o,
  input  logic [N_CH-1:0]                  cfg_tx_en_i,
  input  logic [N_CH-1:0]                  cfg_tx_pending_i,
  input  logic [N_CH*L2_AWIDTH_NOAL-1:0]   cfg_tx_curr_addr_i,
  input  logic [N_CH*TRANS_SIZE-1:0]       cfg_tx_bytes_left_i,

  input  logic                             seot_i,
  input  logic                             rx_ovf_i,
  input  logic                             tx_udf_i,
  output logic                             irq_o,

  output logic                             cfgcpol,
  output logic                             cfgcpha,
  output logic                             cfglsbfirst,
  output logic [3:0]                       cfgwordlen,
  output logic [15:0]                      cfgrxcnt,
  output logic [15:0]                      cfgtxcnt,
  output logic [15:0]                      cfgdmcnt
);

  localparam int unsigned AW = L2_AWIDTH_NOAL;
  localparam int unsigned TS = TRANS_SIZE;

  localparam logic [5:0] ADDR_SETUP  = 6'd32;
  localparam logic [5:0] ADDR_IRQEN  = 6'd33;
  localparam logic [5:0] ADDR_IRQST  = 6'd34;
  localparam logic [5:0] ADDR_SEOT   = 6'd35;
  localparam logic [5:0] ADDR_RXCNT  = 6'd36;
  localparam logic [5:0] ADDR_TXCNT  = 6'd37;
  localparam logic [5:0] ADDR_DMCNT  = 6'd38;
  localparam logic [5:0] ADDR_VER    = 6'd39;

  // Channel register state
  logic [AW-1:0]    r_rx_saddr [N_CH];
  logic [TS-1:0]    r_rx_size  [N_CH];
  logic [AW-1:0]    r_tx_saddr [N_CH];
  logic [TS-1:0]    r_tx_size  [N_CH];
  logic [N_CH-1:0]  r_rx_cont, r_rx_en, r_rx_clr;
  logic [N_CH-1:0]  r_tx_cont, r_tx_en, r_tx_clr;

  // Global register state
  logic             r_cpol, r_cpha, r_lsb;
  logic [3:0]       r_wl;
  logic [2:0]       r_irq_en, r_status;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_rxcnt, r_txcnt, r_dmcnt;
  logic             r_irq;

  // Decode
  logic             w_wr, w_rd, w_chsel;
  logic [1:0]       w_ch;
  logic [2:0]       w_off;
  logic [2:0]       w_status_next, w_irq_en_next;
  logic [CNT_W-1:0] w_cnt_base, w_cnt_next;
  logic             w_unused_data;

  assign w_wr          = cfg_valid_i & ~cfg_rwn_i;
  assign w_rd          = cfg_valid_i &  cfg_rwn_i;
  assign w_chsel       = ~cfg_addr_i[5];
  assign w_ch          = cfg_addr_i[4:3];
  assign w_off         = cfg_addr_i[2:0];
  assign w_unused_data = ^cfg_data_i;

  assign cfg_ready_o = 1'b1;

  // Flatten per-channel registers onto the packed output buses
  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign cfg_rx_startaddr_o[g*AW +: AW] = r_rx_saddr[g];
    assign cfg_rx_size_o[g*TS +: TS]      = r_rx_size[g];
    assign cfg_tx_startaddr_o[g*AW +: AW] = r_tx_saddr[g];
    assign cfg_tx_size_o[g*TS +: TS]      = r_tx_size[g];
  end

  assign cfg_rx_continuous_o = r_rx_cont;
  assign cfg_rx_en_o         = r_rx_en;
  assign cfg_rx_clr_o        = r_rx_clr;
  assign cfg_tx_continuous_o = r_tx_cont;
  assign cfg_tx_en_o         = r_tx_en;
  assign cfg_tx_clr_o        = r_tx_clr;

  assign cfgcpol     = r_cpol;
  assign cfgcpha     = r_cpha;
  assign cfglsbfirst = r_lsb;
  assign cfgwordlen  = r_wl;
  assign cfgrxcnt    = r_rxcnt;
  assign cfgtxcnt    = r_txcnt;
  assign cfgdmcnt    = r_dmcnt;
  assign irq_o       = r_irq;

  // Next-state for IRQ status/mask and SEOT counter; an event set beats a
  // same-cycle W1C, and a same-cycle counter write still sees the increment
  always_comb begin
    w_status_next = r_status;
    w_irq_en_next = r_irq_en;
    w_cnt_base    = r_cnt;
    w_cnt_next    = r_cnt;
    if (w_wr && cfg_addr_i == ADDR_IRQST)
      w_status_next = r_status & ~cfg_data_i[2:0];
    w_status_next = w_status_next | {tx_udf_i, rx_ovf_i, seot_i};
    if (w_wr && cfg_addr_i == ADDR_IRQEN)
      w_irq_en_next = cfg_data_i[2:0];
    if (w_wr && cfg_addr_i == ADDR_SEOT)
      w_cnt_base = cfg_data_i[CNT_W-1:0];
    w_cnt_next = w_cnt_base;
    if (seot_i) begin
      if ((CNT_SAT != 0) && (w_cnt_base == '1))
        w_cnt_next = w_cnt_base;
      else
        w_cnt_next = w_cnt_base + CNT_W'(1);
    end
  end

  // Channel registers; en/clr are single-cycle pulses cleared every cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        r_rx_saddr[c] <= '0;
        r_rx_size[c]  <= '0;
        r_tx_saddr[c] <= '0;
        r_tx_size[c]  <= '0;
      end
      r_rx_cont <= '0;
      r_rx_en   <= '0;
      r_rx_clr  <= '0;
      r_tx_cont <= '0;
      r_tx_en   <= '0;
      r_tx_clr  <= '0;
    end else begin
      r_rx_en  <= '0;
      r_rx_clr <= '0;
      r_tx_en  <= '0;
      r_tx_clr <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (w_wr && w_chsel && (w_ch == 2'(c))) begin
          case (w_off)
            3'd0: r_rx_saddr[c] <= cfg_data_i[AW-1:0];
            3'd1: r_rx_size[c]  <= cfg_data_i[TS-1:0];
            3'd2: begin
              r_rx_cont[c] <= cfg_data_i[0];
              r_rx_en[c]   <= cfg_data_i[4];
              r_rx_clr[c]  <= cfg_data_i[6];
            end
            3'd3: r_tx_saddr[c] <= cfg_data_i[AW-1:0];
            3'd4: r_tx_size[c]  <= cfg_data_i[TS-1:0];
            3'd5: begin
              r_tx_cont[c] <= cfg_data_i[0];
              r_tx_en[c]   <= cfg_data_i[4];
              r_tx_clr[c]  <= cfg_data_i[6];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Global setup, frame lengths, IRQ block and event counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_lsb    <= 1'b0;
      r_wl     <= 4'h7;
      r_irq_en <= '0;
      r_status <= '0;
      r_cnt    <= '0;
      r_rxcnt  <= '0;
      r_txcnt  <= '0;
      r_dmcnt  <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && cfg_addr_i == ADDR_SETUP) begin
        r_cpol <= cfg_data_i[0];
        r_cpha <= cfg_data_i[1];
        r_lsb  <= cfg_data_i[2];
        r_wl   <= cfg_data_i[7:4];
      end
      if (w_wr && cfg_addr_i == ADDR_RXCNT) r_rxcnt <= cfg_data_i[15:0];
      if (w_wr && cfg_addr_i == ADDR_TXCNT) r_txcnt <= cfg_data_i[15:0];
      if (w_wr && cfg_addr_i == ADDR_DMCNT) r_dmcnt <= cfg_data_i[15:0];
      r_irq_en <= w_irq_en_next;
      r_status <= w_status_next;
      r_cnt    <= w_cnt_next;
      r_irq    <= |(w_status_next & w_irq_en_next);
    end
  end

  // Combinational, side-effect-free read mux
  always_comb begin
    cfg_data_o = '0;
    if (w_rd) begin
      if (w_chsel) begin
        for (int unsigned c = 0; c < N_CH; c++) begin
          if (w_ch == 2'(c)) begin
            case (w_off)
              3'd0: cfg_data_o = 32'(cfg_rx_curr_addr_i[c*AW +: AW]);
              3'd1: cfg_data_o = 32'(cfg_rx_bytes_left_i[c*TS +: TS]);
              3'd2: cfg_data_o = {26'h0, cfg_rx_pending_i[c], cfg_rx_en_i[c], 3'h0, r_rx_cont[c]};
              3'd3: cfg_data_o = 32'(cfg_tx_curr_addr_i[c*AW +: AW]);
              3'd4: cfg_data_o = 32'(cfg_tx_bytes_left_i[c*TS +: TS]);
              3'd5: cfg_data_o = {26'h0, cfg_tx_pending_i[c], cfg_tx_en_i[c], 3'h0, r_tx_cont[c]};
              default: cfg_data_o = '0;
            endcase
          end
        end
      end else begin
        case (cfg_addr_i)
          ADDR_SETUP: cfg_data_o = {24'h0, r_wl, 1'b0, r_lsb, r_cpha, r_cpol};
          ADDR_IRQEN: cfg_data_o = {29'h0, r_irq_en};
          ADDR_IRQST: cfg_data_o = {29'h0, r_status};
          ADDR_SEOT:  cfg_data_o = 32'(r_cnt);
          ADDR_RXCNT: cfg_data_o = {16'h0, r_rxcnt};
          ADDR_TXCNT: cfg_data_o = {16'h0, r_txcnt};
          ADDR_DMCNT: cfg_data_o = {16'h0, r_dmcnt};
          ADDR_VER:   cfg_data_o = 32'h0002_0000 | 32'(N_CH);
          default:    cfg_data_o = '0;
        endcase
      end
    end
  end

endmodule
